dmem_mmio_ctrl: RTL and testbench



---
 rtl/dmem_mmio_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dmem_mmio_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_ctrl.sv
// dmem_mmio_ctrl: data RAM + MMIO block (TX FIFO, RX port, cycle counter) behind the MEM stage.
// Ports: clk/rst, core bus (daddr_i, we_i, re_i, wdata_i, rdata_o), halt_i, err_o,
//   TX drain (tx_data_o, tx_valid_o, tx_ready_i), RX source (rx_data_i, rx_valid_i, rx_ready_o).
// Optional: define MMIO_RX_EN to enable the RX path.
module dmem_mmio_ctrl #(
  parameter int          DMEM_WIDTH   = 32,
  parameter int          DMEM_WORDS   = 4096,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
  parameter int          TXFIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DMEM_WIDTH-1:0] daddr_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DMEM_WIDTH-1:0] wdata_i,
  output logic [DMEM_WIDTH-1:0] rdata_o,
  input  logic                  halt_i,
  output logic                  err_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o
);

  localparam int DW = DMEM_WIDTH;
  localparam int AW = $clog2(DMEM_WORDS);
  localparam int PW = $clog2(TXFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DW:0] RAM_BYTES = (DW+1)'(4 * DMEM_WORDS);

  localparam logic [13:0] OFF_TX = 14'd0;
  localparam logic [13:0] OFF_ST = 14'd1;
  localparam logic [13:0] OFF_RX = 14'd2;
  localparam logic [13:0] OFF_CY = 14'd3;

  logic          mmio_sel;
  logic          ram_sel;
  logic          misal;
  logic          unmap;
  logic          bad;
  logic [13:0]   woff;
  logic [AW-1:0] ram_idx;

  logic hit_tx;
  logic hit_st;
  logic hit_rx;
  logic hit_cy;

  logic          rx_v;
  logic [7:0]    rx_d;

  logic [DW-1:0] ram [DMEM_WORDS];

  logic [7:0]    fifo [TXFIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;

  logic          tx_ovf;
  logic          bus_err;
  logic          err_q;
  logic [DW-1:0] cyc;

  logic [DW-1:0] status;
  logic [DW-1:0] mmio_rd;

`ifdef MMIO_RX_EN
  assign rx_v = rx_valid_i;
  assign rx_d = rx_data_i;
`else
  logic unused_rx;
  assign rx_v      = 1'b0;
  assign rx_d      = 8'h00;
  assign unused_rx = ^{rx_valid_i, rx_data_i};
`endif

  assign mmio_sel = daddr_i[31:16] == MMIO_BASE[31:16];
  assign ram_sel  = !mmio_sel && ({1'b0, daddr_i} < RAM_BYTES);
  assign unmap    = !mmio_sel && !ram_sel;
  assign misal    = daddr_i[1:0] != 2'b00;
  assign bad      = (we_i & re_i) |
                    ((we_i | re_i) & (misal | unmap));
  assign woff     = daddr_i[15:2];
  assign ram_idx  = daddr_i[AW+1:2];

  assign hit_tx = mmio_sel && (woff == OFF_TX);
  assign hit_st = mmio_sel && (woff == OFF_ST);
  assign hit_rx = mmio_sel && (woff == OFF_RX);
  assign hit_cy = mmio_sel && (woff == OFF_CY);

  always_ff @(posedge clk) begin
    if (we_i && ram_sel) begin
      ram[ram_idx] <= wdata_i;
    end
  end

  assign full       = cnt == CW'(TXFIFO_DEPTH);
  assign empty      = cnt == '0;
  assign tx_valid_o = !empty;
  assign pop        = tx_valid_o & tx_ready_i;
  assign push_req   = we_i & hit_tx;
  // A full FIFO still accepts a push when the head drains the same cycle.
  assign push       = push_req & (!full | pop);
  assign drop       = push_req & full & !pop;
  assign tx_data_o  = empty ? 8'h00 : fifo[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= wdata_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Sticky flags: a new event in the same cycle as a W1C write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf  <= 1'b0;
      bus_err <= 1'b0;
      err_q   <= 1'b0;
      cyc     <= '0;
    end else begin
      err_q <= bad;
      if (we_i && hit_st && wdata_i[9])  tx_ovf  <= 1'b0;
      if (drop)                          tx_ovf  <= 1'b1;
      if (we_i && hit_st && wdata_i[10]) bus_err <= 1'b0;
      if (bad)                           bus_err <= 1'b1;
      if (we_i && hit_cy) begin
        cyc <= wdata_i;
      end else if (!halt_i) begin
        cyc <= cyc + 1'b1;
      end
    end
  end

  assign err_o      = err_q;
  assign rx_ready_o = re_i & hit_rx & rx_v;

  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[6:2] = 5'(cnt);
    status[8]   = rx_v;
    status[9]   = tx_ovf;
    status[10]  = bus_err;
  end

  always_comb begin
    mmio_rd = '0;
    unique case (1'b1)
      hit_st:  mmio_rd = status;
      hit_rx:  mmio_rd = rx_v ? {{(DW-8){1'b0}}, rx_d} : '0;
      hit_cy:  mmio_rd = cyc;
      default: mmio_rd = '0;
    endcase
  end

  always_comb begin
    rdata_o = '0;
    if (re_i) begin
      unique case (1'b1)
        mmio_sel: rdata_o = mmio_rd;
        ram_sel:  rdata_o = ram[ram_idx];
        default:  rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// tb_dmem_mmio_ctrl: directed scenarios plus randomized traffic against a queue-based model.
// Drives the core bus, TX sink and RX source of dmem_mmio_ctrl.
module tb_dmem_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] daddr_i;
  logic        we_i;
  logic        re_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        halt_i;
  logic        err_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;

  int checks = 0;
  int errors = 0;

`ifdef MMIO_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  dmem_mmio_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .daddr_i    (daddr_i),
    .we_i       (we_i),
    .re_i       (re_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .halt_i     (halt_i),
    .err_o      (err_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o)
  );

  always #5 clk = ~clk;

  logic [31:0] m_ram [int];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  bit          m_berr;
  logic [31:0] m_cyc;
  bit          m_err;

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = 0; re_i = 0; daddr_i = 0; wdata_i = 0; halt_i = 0;
    tx_ready_i = 0; rx_valid_i = 0; rx_data_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    clk_step();
    clk_step();
    rst = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1; re_i = 0; daddr_i = a; wdata_i = d;
    clk_step();
    we_i = 0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    int c = m_q.size();
    s[0] = (c == 8);
    s[1] = (c == 0);
    s[6:2] = 5'(c);
    s[8] = RX_EN & rx_valid_i;
    s[9] = m_ovf;
    s[10] = m_berr;
    return s;
  endfunction

  task automatic model_comb(output logic [31:0] rd, output bit known, output logic rxr);
    bit mm = daddr_i[31:16] == 16'hFFFF;
    bit rm = daddr_i < 32'h4000;
    logic [15:0] off = {daddr_i[15:2], 2'b00};
    int idx = int'(daddr_i[13:2]);
    rd = 0; known = 1; rxr = 0;
    if (re_i && mm) begin
      case (off)
        16'h4: rd = m_status();
        16'h8: rd = (RX_EN && rx_valid_i) ? {24'h0, rx_data_i} : 32'h0;
        16'hC: rd = m_cyc;
        default: rd = 0;
      endcase
      rxr = RX_EN && rx_valid_i && off == 16'h8;
    end else if (re_i && rm) begin
      if (m_ram.exists(idx)) rd = m_ram[idx];
      else known = 0;
    end
  endtask

  task automatic model_next();
    bit mm = daddr_i[31:16] == 16'hFFFF;
    bit rm = daddr_i < 32'h4000;
    logic [15:0] off = {daddr_i[15:2], 2'b00};
    bit bad;
    bit popd;
    bit was_full;
    bad = (we_i && re_i) ||
          ((we_i || re_i) && (daddr_i[1:0] != 0 || (!mm && !rm)));
    if (we_i && rm) m_ram[int'(daddr_i[13:2])] = wdata_i;
    if (we_i && mm && off == 16'h4) begin
      if (wdata_i[9]) m_ovf = 0;
      if (wdata_i[10]) m_berr = 0;
    end
    if (bad) m_berr = 1;
    if (we_i && mm && off == 16'hC) m_cyc = wdata_i;
    else if (!halt_i) m_cyc = m_cyc + 1;
    popd = m_q.size() > 0 && tx_ready_i;
    was_full = m_q.size() == 8;
    if (popd) void'(m_q.pop_front());
    if (we_i && mm && off == 16'h0) begin
      if (was_full && !popd) m_ovf = 1;
      else m_q.push_back(wdata_i[7:0]);
    end
    m_err = bad;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_o); end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_txv got %0b want 0", tx_valid_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_txd got %h want 00", tx_data_o); end
    checks++; if (rx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rxr got %0b want 0", rx_ready_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    re_i = 1; daddr_i = 32'hFFFF_0004;
    #1;
    checks++; if (rdata_o !== 32'h2) begin errors++; $display("FAIL reset_status got %h want 00000002", rdata_o); end
    re_i = 0;
    clk_step();
  endtask

  task automatic test_ram();
    wr(32'h100, 32'hDEADBEEF);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ram_wr_err got %0b want 0", err_o); end
    re_i = 1; daddr_i = 32'h100;
    #1;
    checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd got %h want deadbeef", rdata_o); end
    clk_step();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ram_rd_err got %0b want 0", err_o); end
    we_i = 1; wdata_i = 32'h12345678;
    #1;
    checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rw_old got %h want deadbeef", rdata_o); end
    clk_step();
    we_i = 0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ram_rw_err got %0b want 1", err_o); end
    daddr_i = 32'h102;
    #1;
    checks++; if (rdata_o !== 32'h12345678) begin errors++; $display("FAIL ram_misal_rd got %h want 12345678", rdata_o); end
    clk_step();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ram_misal_err got %0b want 1", err_o); end
    re_i = 0;
    #1;
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL ram_re0 got %h want 0", rdata_o); end
    wr(32'h3FFC, 32'hA5A5_5A5A);
    re_i = 1; daddr_i = 32'h3FFC;
    #1;
    checks++; if (rdata_o !== 32'hA5A5_5A5A) begin errors++; $display("FAIL ram_last got %h want a5a55a5a", rdata_o); end
    daddr_i = 32'h4000;
    #1;
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL ram_past_end got %h want 0", rdata_o); end
    clk_step();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ram_past_end_err got %0b want 1", err_o); end
    re_i = 0;
    wr(32'hFFFF_0004, 32'h400);
  endtask

  task automatic test_tx_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) wr(32'hFFFF_0000, 32'(i));
    re_i = 1; daddr_i = 32'hFFFF_0004;
    #1;
    checks++; if (rdata_o !== 32'h221) begin errors++; $display("FAIL ovf_status got %h want 00000221", rdata_o); end
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h01) begin errors++; $display("FAIL ovf_head got %0b/%h want 1/01", tx_valid_o, tx_data_o); end
    re_i = 0; tx_ready_i = 1;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'(k)) begin
        errors++; $display("FAIL ovf_drain%0d got %0b/%h want 1/%h", k, tx_valid_o, tx_data_o, 8'(k));
      end
      clk_step();
    end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b want 0", tx_valid_o); end
    tx_ready_i = 0;
    wr(32'hFFFF_0004, 32'h200);
    re_i = 1; daddr_i = 32'hFFFF_0004;
    #1;
    checks++; if (rdata_o !== 32'h2) begin errors++; $display("FAIL ovf_clear got %h want 00000002", rdata_o); end
    re_i = 0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
    do_reset();
    for (int i = 0; i < 8; i++) wr(32'hFFFF_0000, 32'h10 + 32'(i));
    tx_ready_i = 1;
    wr(32'hFFFF_0000, 32'hAA);
    tx_ready_i = 0;
    re_i = 1; daddr_i = 32'hFFFF_0004;
    #1;
    checks++; if (rdata_o !== 32'h21) begin errors++; $display("FAIL fpp_status got %h want 00000021", rdata_o); end
    re_i = 0; tx_ready_i = 1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== exp_b[k]) begin
        errors++; $display("FAIL fpp_drain%0d got %0b/%h want 1/%h", k, tx_valid_o, tx_data_o, exp_b[k]);
      end
      clk_step();
    end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL fpp_empty got %0b want 0", tx_valid_o); end
    tx_ready_i = 0;
  endtask

  task automatic test_unmapped();
    re_i = 1; daddr_i = 32'h0001_0000;
    #1;
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL unm_rd got %h want 0", rdata_o); end
    clk_step();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL unm_err got %0b want 1", err_o); end
    daddr_i = 32'hFFFF_0004;
    #1;
    checks++; if (rdata_o[10] !== 1'b1) begin errors++; $display("FAIL unm_sticky got %0b want 1", rdata_o[10]); end
    clk_step();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL unm_pulse got %0b want 0", err_o); end
    re_i = 0;
    wr(32'hFFFF_0004, 32'h400);
    re_i = 1; daddr_i = 32'hFFFF_0004;
    #1;
    checks++; if (rdata_o[10] !== 1'b0) begin errors++; $display("FAIL unm_w1c got %0b want 0", rdata_o[10]); end
    re_i = 0;
  endtask

  task automatic test_cycle();
    halt_i = 0;
    wr(32'hFFFF_000C, 32'h10);
    repeat (5) clk_step();
    halt_i = 1; re_i = 1; daddr_i = 32'hFFFF_000C;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rdata_o !== 32'h15) begin errors++; $display("FAIL cyc_halt%0d got %h want 00000015", k, rdata_o); end
      clk_step();
    end
    halt_i = 0; re_i = 0;
  endtask

  task automatic test_rx();
    rx_valid_i = 1; rx_data_i = 8'h5A;
    #1;
    checks++; if (rx_ready_o !== 1'b0) begin errors++; $display("FAIL rx_idle got %0b want 0", rx_ready_o); end
    re_i = 1; daddr_i = 32'hFFFF_0008;
    #1;
    checks++; if (rdata_o !== (RX_EN ? 32'h5A : 32'h0)) begin errors++; $display("FAIL rx_rd got %h want %h", rdata_o, RX_EN ? 32'h5A : 32'h0); end
    checks++; if (rx_ready_o !== RX_EN) begin errors++; $display("FAIL rx_pulse got %0b want %0b", rx_ready_o, RX_EN); end
    daddr_i = 32'hFFFF_0004;
    #1;
    checks++; if (rdata_o[8] !== RX_EN) begin errors++; $display("FAIL rx_status got %0b want %0b", rdata_o[8], RX_EN); end
    clk_step();
    rx_valid_i = 0; daddr_i = 32'hFFFF_0008;
    #1;
    checks++; if (rdata_o !== 32'h0 || rx_ready_o !== 1'b0) begin errors++; $display("FAIL rx_novalid got %h/%0b want 0/0", rdata_o, rx_ready_o); end
    re_i = 0;
    clk_step();
  endtask

  task automatic test_random();
    logic [31:0] erd;
    bit known;
    logic erx;
    bit slow;
    do_reset();
    m_q.delete(); m_ovf = 0; m_berr = 0; m_cyc = 0; m_err = 0;
    for (int n = 0; n < 1500; n++) begin
      slow = ((n / 100) % 2) == 0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: daddr_i = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
        4: case ($urandom_range(0, 2))
             0: daddr_i = 32'h3FFC;
             1: daddr_i = 32'h4000;
             default: daddr_i = 32'($urandom_range(0, 255));
           endcase
        5, 6, 7: case ($urandom_range(0, 7))
                   0, 1, 2, 3: daddr_i = 32'hFFFF_0000;
                   4: daddr_i = 32'hFFFF_0004;
                   5: daddr_i = 32'hFFFF_0008;
                   6: daddr_i = 32'hFFFF_000C;
                   default: daddr_i = 32'hFFFF_0010;
                 endcase
        8: daddr_i = 32'hFFFF_0000 + 32'($urandom_range(0, 15));
        default: begin
          daddr_i = $urandom();
          if (daddr_i[31:16] == 16'hFFFF || daddr_i < 32'h4000) daddr_i = 32'h1234_5678;
        end
      endcase
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7: begin we_i = 0; re_i = 1; end
        8, 9, 10, 11, 12, 13, 14, 15: begin we_i = 1; re_i = 0; end
        16: begin we_i = 1; re_i = 1; end
        default: begin we_i = 0; re_i = 0; end
      endcase
      wdata_i = $urandom();
      halt_i = $urandom_range(0, 3) == 0;
      tx_ready_i = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      rx_valid_i = $urandom_range(0, 1) == 1;
      rx_data_i = 8'($urandom());
      #1;
      model_comb(erd, known, erx);
      if (known) begin
        checks++;
        if (rdata_o !== erd) begin errors++; $display("FAIL rnd_rdata n=%0d a=%h got %h want %h", n, daddr_i, rdata_o, erd); end
      end
      checks++;
      if (rx_ready_o !== erx) begin errors++; $display("FAIL rnd_rxr n=%0d got %0b want %0b", n, rx_ready_o, erx); end
      model_next();
      clk_step();
      checks++;
      if (err_o !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %0b want %0b", n, err_o, m_err); end
      checks++;
      if (tx_valid_o !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_txv n=%0d got %0b want %0d", n, tx_valid_o, m_q.size() > 0); end
      checks++;
      if (tx_data_o !== (m_q.size() > 0 ? m_q[0] : 8'h00)) begin
        errors++; $display("FAIL rnd_txd n=%0d got %h want %h", n, tx_data_o, m_q.size() > 0 ? m_q[0] : 8'h00);
      end
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) wr(32'hFFFF_0000, 32'h40 + 32'(i));
    rst = 1;
    clk_step();
    rst = 0;
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_txv got %0b want 0", tx_valid_o); end
    clk_step();
  endtask

  initial begin
    idle();
    rst = 0;
    test_reset();
    test_ram();
    test_tx_overflow();
    test_full_push_pop();
    test_unmapped();
    test_cycle();
    test_rx();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
